// File: rtl/gdu_vram_scheduler.sv
// ---------------------------------------------------------------------------
// gdu_vram_scheduler
//
// Purpose:
//   Sequences VRAM write port A of the graphics drawing unit and owns the
//   double-buffer selection. Port A is shared between an internal clear
//   engine (fills the back buffer with one 64-bit word) and one external draw
//   requester. Front/back swaps happen only at the start of vertical sync, so
//   the display always reads the front buffer while every write lands in the
//   back buffer (address bit 16 = ~frame).
//
// Optional feature (macro GDU_SCHED_AUTO_CLEAR_EN):
//   Defined   - every swap is followed directly by a refill of the new back
//               buffer with the last latched clear word (0 after reset).
//   Undefined - after a swap the block returns to idle; clears only happen on
//               i_cmd_clear.
//
// Parameters:
//   WORDS      64-bit words per frame; clear covers 0..WORDS-1 (<= 65536).
//   VS_ACTIVE  level of i_vs during the sync pulse; the swap point is the
//              transition into this level.
//
// Ports:
//   i_clk            system clock (i_vs is synchronous to it)
//   i_rst_n          asynchronous active-low reset
//   i_cmd_clear      pulse: fill back buffer with i_clear_data
//   i_clear_data     fill word, sampled in the i_cmd_clear cycle
//   i_cmd_swap       pulse: swap buffers at next vsync
//   i_draw_req       draw write request, held until granted
//   i_draw_addr      word address within the back buffer
//   i_draw_data      draw write data
//   i_draw_byte_en   draw byte enables
//   o_draw_gnt       combinational: draw write accepted this cycle
//   i_vs             vertical sync
//   o_frame          front-buffer index to the display
//   o_busy           clear or swap in progress or pending (registered)
//   o_swap_done      one-cycle pulse on the cycle o_frame toggles
//   o_vram_addr      port A address, bit 16 = ~frame
//   o_vram_wren      port A write enable
//   o_vram_w_data    port A write data
//   o_vram_byte_en   port A byte enables
// ---------------------------------------------------------------------------
module gdu_vram_scheduler #(
  parameter int WORDS     = 61440,
  parameter bit VS_ACTIVE = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_clear,
  input  logic [63:0] i_clear_data,
  input  logic        i_cmd_swap,
  input  logic        i_draw_req,
  input  logic [15:0] i_draw_addr,
  input  logic [63:0] i_draw_data,
  input  logic [7:0]  i_draw_byte_en,
  output logic        o_draw_gnt,
  input  logic        i_vs,
  output logic        o_frame,
  output logic        o_busy,
  output logic        o_swap_done,
  output logic [16:0] o_vram_addr,
  output logic        o_vram_wren,
  output logic [63:0] o_vram_w_data,
  output logic [7:0]  o_vram_byte_en
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_WAIT_VS = 2'd2
  } state_t;

  localparam logic [15:0] LAST_WORD = 16'(WORDS - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [63:0] r_fill;
  logic        r_swap_pend;
  logic        r_vs_q;
  logic        r_frame;
  logic        r_busy;
  logic        r_swap_done;
  logic [16:0] r_vram_addr;
  logic        r_vram_wren;
  logic [63:0] r_vram_w_data;
  logic [7:0]  r_vram_byte_en;

  state_t      w_state_next;
  logic [15:0] w_cnt_next;
  logic [63:0] w_fill_next;
  logic        w_pend_next;
  logic        w_frame_next;
  logic        w_swap_done_next;
  logic        w_busy_next;
  logic        w_gnt;
  logic        w_wr_en;
  logic [16:0] w_wr_addr;
  logic [63:0] w_wr_data;
  logic [7:0]  w_wr_be;
  logic        w_vs_start;

  // Swap point: first cycle vs is at the active level.
  assign w_vs_start = (i_vs == VS_ACTIVE) && (r_vs_q != VS_ACTIVE);

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_fill_next      = r_fill;
    w_pend_next      = r_swap_pend;
    w_frame_next     = r_frame;
    w_swap_done_next = 1'b0;
    w_gnt            = 1'b0;
    w_wr_en          = 1'b0;
    w_wr_addr        = r_vram_addr;
    w_wr_data        = r_vram_w_data;
    w_wr_be          = r_vram_byte_en;

    case (r_state)
      ST_IDLE: begin
        // A clear command in the same cycle wins port A from the requester.
        w_gnt = i_draw_req && !i_cmd_clear && !r_swap_pend;
        if (w_gnt) begin
          w_wr_en   = 1'b1;
          w_wr_addr = {~r_frame, i_draw_addr};
          w_wr_data = i_draw_data;
          w_wr_be   = i_draw_byte_en;
        end
        if (i_cmd_clear) begin
          w_fill_next  = i_clear_data;
          w_cnt_next   = '0;
          w_state_next = ST_CLEAR;
          if (i_cmd_swap) begin
            w_pend_next = 1'b1;
          end
        end else if (i_cmd_swap) begin
          w_state_next = ST_WAIT_VS;
        end
      end

      ST_CLEAR: begin
        w_wr_en   = 1'b1;
        w_wr_addr = {~r_frame, r_cnt};
        w_wr_data = r_fill;
        w_wr_be   = 8'hFF;
        if (i_cmd_swap) begin
          w_pend_next = 1'b1;
        end
        if (r_cnt == LAST_WORD) begin
          // Counter is left at the last word; no wrap past WORDS-1.
          w_state_next = w_pend_next ? ST_WAIT_VS : ST_IDLE;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end

      ST_WAIT_VS: begin
        // Draw is held off so nothing tears into the buffer being promoted.
        if (w_vs_start) begin
          w_frame_next     = ~r_frame;
          w_swap_done_next = 1'b1;
          w_pend_next      = 1'b0;
`ifdef GDU_SCHED_AUTO_CLEAR_EN
          w_cnt_next   = '0;
          w_state_next = ST_CLEAR;
`else
          w_state_next = ST_IDLE;
`endif
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Computed from the next state so busy rises the cycle after a command.
    w_busy_next = (w_state_next != ST_IDLE) || w_pend_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_fill         <= '0;
      r_swap_pend    <= 1'b0;
      r_vs_q         <= ~VS_ACTIVE;
      r_frame        <= 1'b0;
      r_busy         <= 1'b0;
      r_swap_done    <= 1'b0;
      r_vram_addr    <= '0;
      r_vram_wren    <= 1'b0;
      r_vram_w_data  <= '0;
      r_vram_byte_en <= '0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_fill         <= w_fill_next;
      r_swap_pend    <= w_pend_next;
      r_vs_q         <= i_vs;
      r_frame        <= w_frame_next;
      r_busy         <= w_busy_next;
      r_swap_done    <= w_swap_done_next;
      r_vram_addr    <= w_wr_addr;
      r_vram_wren    <= w_wr_en;
      r_vram_w_data  <= w_wr_data;
      r_vram_byte_en <= w_wr_be;
    end
  end

  assign o_draw_gnt     = w_gnt;
  assign o_frame        = r_frame;
  assign o_busy         = r_busy;
  assign o_swap_done    = r_swap_done;
  assign o_vram_addr    = r_vram_addr;
  assign o_vram_wren    = r_vram_wren;
  assign o_vram_w_data  = r_vram_w_data;
  assign o_vram_byte_en = r_vram_byte_en;

endmodule
